// File: rtl/dma_to_axi_lite_if.sv
// dma_to_axi_lite_if: DMA request/response bundle and AXI4-Lite bundle
interface dma_if #(
    parameter int addr_width_p = 64,
    parameter int data_width_p = 64
);
    logic                      v;
    logic                      ready;
    logic                      we;
    logic [addr_width_p-1:0]   addr;
    logic [data_width_p/8-1:0] be;
    logic [data_width_p-1:0]   data;
    logic                      resp_v;
    logic                      resp_ready;
    logic [data_width_p-1:0]   resp_data;
    logic                      err;
    modport master (output v, we, addr, be, data, resp_ready, input ready, resp_v, resp_data, err);
    modport slave  (input v, we, addr, be, data, resp_ready, output ready, resp_v, resp_data, err);
endinterface

interface axil_if #(
    parameter int addr_width_p = 64,
    parameter int data_width_p = 64
);
    logic                      awvalid;
    logic                      awready;
    logic [addr_width_p-1:0]   awaddr;
    logic                      wvalid;
    logic                      wready;
    logic [data_width_p-1:0]   wdata;
    logic [data_width_p/8-1:0] wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [addr_width_p-1:0]   araddr;
    logic                      rvalid;
    logic                      rready;
    logic [data_width_p-1:0]   rdata;
    logic [1:0]                rresp;
    modport master (output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
                    input awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp);
    modport slave  (input awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
                    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp);
endinterface

// File: rtl/dma_to_axi_lite.sv
// dma_to_axi_lite: single-beat DMA requests to one-at-a-time AXI4-Lite transactions
module dma_to_axi_lite #(
    parameter int addr_width_p = 64,
    parameter int data_width_p = 64
) (
    input  logic   clk_i,
    input  logic   reset_n_i,
    dma_if.slave   dma,
    axil_if.master axi
);
    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RRESP} state_e;

    state_e                    state_q, state_d;
    logic [addr_width_p-1:0]   addr_q;
    logic [data_width_p/8-1:0] strb_q;
    logic [data_width_p-1:0]   wdata_q, rdata_q;
    logic                      awvalid_q, wvalid_q, arvalid_q, err_q;
    logic                      accept, aw_done, w_done, b_hs, r_hs;

    assign accept  = dma.v && state_q == IDLE;
    assign aw_done = !awvalid_q || axi.awready;
    assign w_done  = !wvalid_q || axi.wready;
    assign b_hs    = state_q == WRESP && axi.bvalid;
    assign r_hs    = state_q == RDATA && axi.rvalid;

    assign dma.ready     = state_q == IDLE;
    assign dma.resp_v    = state_q == RRESP;
    assign dma.resp_data = rdata_q;
    assign dma.err       = err_q;
    assign axi.awvalid   = awvalid_q;
    assign axi.awaddr    = addr_q;
    assign axi.wvalid    = wvalid_q;
    assign axi.wdata     = wdata_q;
    assign axi.wstrb     = strb_q;
    assign axi.bready    = state_q == WRESP;
    assign axi.arvalid   = arvalid_q;
    assign axi.araddr    = addr_q;
    assign axi.rready    = state_q == RDATA;

    // state register; reset abandons any transaction in flight
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // next state; AW and W may complete in either order or together
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dma.v) state_d = dma.we ? WADDR : RADDR;
            WADDR:   if (aw_done && w_done) state_d = WRESP;
            WRESP:   if (axi.bvalid) state_d = IDLE;
            RADDR:   if (axi.arready) state_d = RDATA;
            RDATA:   if (axi.rvalid) state_d = RRESP;
            RRESP:   if (dma.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // request capture, per-channel valids, read data and sticky error
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            addr_q    <= '0;
            strb_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                addr_q    <= dma.addr;
                strb_q    <= dma.be;
                wdata_q   <= dma.data;
                awvalid_q <= dma.we;
                wvalid_q  <= dma.we;
                arvalid_q <= !dma.we;
            end else begin
                awvalid_q <= awvalid_q && !axi.awready;
                wvalid_q  <= wvalid_q && !axi.wready;
                arvalid_q <= arvalid_q && !axi.arready;
            end
            if (r_hs) rdata_q <= axi.rdata;
            if ((b_hs && axi.bresp != 2'b00) || (r_hs && axi.rresp != 2'b00)) err_q <= 1'b1;
        end
    end
endmodule
